// File: rtl/pair_pack_pkg.sv
// Shared definitions for the pair-packing arbiter: FSM encoding, ID and counter widths.
package pair_pack_pkg;

  localparam int ID_W    = 2;
  localparam int CNT_W   = 8;
  localparam int MAX_REQ = 2 ** ID_W;

  typedef logic [ID_W-1:0] id_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HI   = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module rr_pick
  import pair_pack_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] req,
  input  id_t              ptr,
  output id_t              win,
  output logic             any
);

  logic [MAX_REQ-1:0]   req_ext;
  logic [2*MAX_REQ-1:0] dbl;
  logic [MAX_REQ-1:0]   rot;

  // Unused upper request slots are zero, so rotating modulo MAX_REQ keeps N_REQ order.
  assign req_ext = MAX_REQ'(req);
  assign dbl     = {req_ext, req_ext} >> ptr;
  assign rot     = dbl[MAX_REQ-1:0];
  assign any     = |rot;

  always_comb begin
    win = ptr;
    if (rot[0])      win = ptr;
    else if (rot[1]) win = ptr + id_t'(1);
    else if (rot[2]) win = ptr + id_t'(2);
    else if (rot[3]) win = ptr + id_t'(3);
  end

endmodule

// File: rtl/pair_pack_arbiter.sv
// Round-robin arbiter that packs two consecutive words from one requester into a pair.
// Optional pair timeout enabled by defining PAIR_PACK_TIMEOUT_EN.
module pair_pack_arbiter
  import pair_pack_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int N_REQ        = 2,
  parameter int PAIR_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ*DATA_W-1:0] i_data,
  input  logic [N_REQ-1:0]        i_valid,
  output logic [N_REQ-1:0]        o_ready,
  input  logic                    clear,
  output logic [2*DATA_W-1:0]     o_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [ID_W-1:0]         o_id,
  output logic                    o_partial
);

  generate
    if (N_REQ < 2 || N_REQ > MAX_REQ) begin : g_bad_nreq
      $error("pair_pack_arbiter: N_REQ out of range");
    end
    if (PAIR_TIMEOUT < 2 || PAIR_TIMEOUT > 255) begin : g_bad_timeout
      $error("pair_pack_arbiter: PAIR_TIMEOUT out of range");
    end
  endgenerate

  logic [1:0]         state;
  id_t                ptr;
  id_t                gnt;
  id_t                win;
  logic               any;
  logic [MAX_REQ-1:0] valid_ext;
  logic [MAX_REQ-1:0] ready_ext;
  logic [DATA_W-1:0]  words [MAX_REQ];

  // Word table padded to MAX_REQ entries so a 2-bit id indexes it directly.
  generate
    for (genvar k = 0; k < MAX_REQ; k++) begin : g_words
      if (k < N_REQ) begin : g_used
        assign words[k] = i_data[k*DATA_W +: DATA_W];
      end else begin : g_pad
        assign words[k] = '0;
      end
    end
  endgenerate

  assign valid_ext = MAX_REQ'(i_valid);

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req (i_valid),
    .ptr (ptr),
    .win (win),
    .any (any)
  );

  always_comb begin
    ready_ext = '0;
    if (!rst && !clear) begin
      case (state)
        ST_IDLE: ready_ext[win] = any;
        ST_HI:   ready_ext[gnt] = 1'b1;
        default: ready_ext = '0;
      endcase
    end
  end

  assign o_ready = ready_ext[N_REQ-1:0];
  assign o_valid = (state == ST_OUT);
  assign o_id    = gnt;

`ifdef PAIR_PACK_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  logic             partial_q;
  assign o_partial = partial_q;
`else
  assign o_partial = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      gnt    <= '0;
      o_data <= '0;
`ifdef PAIR_PACK_TIMEOUT_EN
      cnt       <= '0;
      partial_q <= 1'b0;
`endif
    end else if (clear) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any) begin
            o_data[DATA_W-1:0] <= words[win];
            gnt                <= win;
            state              <= ST_HI;
`ifdef PAIR_PACK_TIMEOUT_EN
            cnt <= '0;
`endif
          end
        end
        ST_HI: begin
          if (valid_ext[gnt]) begin
            o_data[2*DATA_W-1:DATA_W] <= words[gnt];
            state                     <= ST_OUT;
`ifdef PAIR_PACK_TIMEOUT_EN
            partial_q <= 1'b0;
          end else if (cnt == CNT_W'(PAIR_TIMEOUT - 1)) begin
            o_data[2*DATA_W-1:DATA_W] <= '0;
            partial_q                 <= 1'b1;
            state                     <= ST_OUT;
          end else begin
            cnt <= cnt + 1'b1;
`endif
          end
        end
        ST_OUT: begin
          if (i_ready) begin
            state <= ST_IDLE;
            ptr   <= (gnt == id_t'(N_REQ - 1)) ? '0 : gnt + id_t'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pair_pack_arbiter.sv
// Self-checking bench for pair_pack_arbiter: directed scenarios plus random traffic
// against a transaction-level model; honours PAIR_PACK_TIMEOUT_EN when defined.
module tb_pair_pack_arbiter;

  localparam int DW = 32;
  localparam int NR = 2;
  localparam int PT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic              i_ready;
  logic [NR*DW-1:0]  i_data;
  logic [NR-1:0]     i_valid;
  logic [NR-1:0]     o_ready;
  logic [2*DW-1:0]   o_data;
  logic              o_valid;
  logic [1:0]        o_id;
  logic              o_partial;

  pair_pack_arbiter #(.DATA_W(DW), .N_REQ(NR), .PAIR_TIMEOUT(PT)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .clear     (clear),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_id      (o_id),
    .o_partial (o_partial)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Model: how many words of the current pair are held (0, 1, or 2 = pair waiting).
  int          mHeld = 0;
  int          mPtr = 0;
  int          mOwner = 0;
  int          mWait = 0;
  logic [DW-1:0] mLo = '0;
  logic [DW-1:0] mHi = '0;
  logic        mPartial = 1'b0;
  logic        mJustReset = 1'b1;

  logic [1:0]      dutIds[$];
  logic [2*DW-1:0] dutPairs[$];

  function automatic logic [DW-1:0] wordOf(int k);
    return i_data[k*DW +: DW];
  endfunction

  function automatic int pickFromPtr();
    for (int i = 0; i < NR; i++) begin
      if (i_valid[(mPtr + i) % NR]) return (mPtr + i) % NR;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] modelReady();
    logic [NR-1:0] r;
    int w;
    r = '0;
    if (rst || clear) return r;
    if (mHeld == 0) begin
      w = pickFromPtr();
      if (w >= 0) r[w] = 1'b1;
    end else if (mHeld == 1) begin
      r[mOwner] = 1'b1;
    end
    return r;
  endfunction

  task automatic modelUpdate();
    int w;
    mJustReset = 1'b0;
    if (rst) begin
      mHeld = 0; mPtr = 0; mOwner = 0; mWait = 0;
      mLo = '0; mHi = '0; mPartial = 1'b0; mJustReset = 1'b1;
    end else if (clear) begin
      mHeld = 0;
    end else if (mHeld == 0) begin
      w = pickFromPtr();
      if (w >= 0) begin
        mOwner = w; mLo = wordOf(w); mHeld = 1; mWait = 0;
      end
    end else if (mHeld == 1) begin
      if (i_valid[mOwner]) begin
        mHi = wordOf(mOwner); mPartial = 1'b0; mHeld = 2;
      end
`ifdef PAIR_PACK_TIMEOUT_EN
      else if (mWait == PT - 1) begin
        mHi = '0; mPartial = 1'b1; mHeld = 2;
      end else begin
        mWait++;
      end
`endif
    end else if (i_ready) begin
      mHeld = 0;
      mPtr = (mOwner + 1) % NR;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [2*DW-1:0] obs, input logic [2*DW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check o_ready mid-cycle, advance model, check outputs.
  task automatic applyStimulus(input logic r, input logic c, input logic [NR-1:0] v,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic rdy);
    rst = r; clear = c; i_valid = v; i_data = {d1, d0}; i_ready = rdy;
    @(negedge clk);
    checkOutput("o_ready", o_ready, modelReady());
    if (o_valid && i_ready && !rst && !clear) begin
      dutIds.push_back(o_id);
      dutPairs.push_back(o_data);
    end
    @(posedge clk);
    modelUpdate();
    #1;
    checkOutput("o_valid", o_valid, mHeld == 2);
    if (mHeld == 2 || mJustReset) begin
      checkOutput("o_data", o_data, mJustReset ? '0 : {mHi, mLo});
      checkOutput("o_id", o_id, mJustReset ? 0 : mOwner);
      checkOutput("o_partial", o_partial, mJustReset ? 1'b0 : mPartial);
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; i_valid = '0; i_data = '0; i_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    applyStimulus(1, 0, 2'b00, 0, 0, 1);
    checkOutput("reset_ready", o_ready, 0);

    // Single requester: 0xA then 0xB
    applyStimulus(0, 0, 2'b01, 32'hA, 0, 1);
    applyStimulus(0, 0, 2'b01, 32'hB, 0, 1);
    checkOutput("single_valid", o_valid, 1);
    checkOutput("single_data", o_data, {32'hB, 32'hA});
    checkOutput("single_id", o_id, 0);
    applyStimulus(0, 0, 2'b00, 0, 0, 1);

    // Fairness from reset with both requesters always valid
    applyStimulus(1, 0, 2'b00, 0, 0, 1);
    dutIds.delete(); dutPairs.delete();
    for (int c = 0; c < 12; c++) applyStimulus(0, 0, 2'b11, 32'h100 + c, 32'h200 + c, 1);
    checkOutput("fair_count", dutIds.size(), 4);
    for (int j = 0; j < 4; j++) begin
      checkOutput("fair_id", dutIds[j], j % 2);
      checkOutput("fair_lo_src", dutPairs[j][11:8], (j % 2) + 1);
      checkOutput("fair_hi_src", dutPairs[j][DW+11:DW+8], (j % 2) + 1);
    end

    // Backpressure during OUT
    applyStimulus(1, 0, 2'b00, 0, 0, 1);
    dutIds.delete(); dutPairs.delete();
    applyStimulus(0, 0, 2'b01, 32'hA, 0, 0);
    applyStimulus(0, 0, 2'b01, 32'hB, 0, 0);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(0, 0, 2'b11, 32'h77, 32'h88, 0);
      checkOutput("bp_ready", o_ready, 0);
      checkOutput("bp_data", o_data, {32'hB, 32'hA});
      checkOutput("bp_id", o_id, 0);
    end
    applyStimulus(0, 0, 2'b00, 0, 0, 1);
    for (int c = 0; c < 3; c++) applyStimulus(0, 0, 2'b00, 0, 0, 1);
    checkOutput("bp_once", dutPairs.size(), 1);
    checkOutput("bp_pair", dutPairs[0], {32'hB, 32'hA});

    // Clear mid-pair; ptr moved to 1 first so its retention is visible
    applyStimulus(1, 0, 2'b00, 0, 0, 1);
    applyStimulus(0, 0, 2'b01, 32'h1, 0, 1);
    applyStimulus(0, 0, 2'b01, 32'h2, 0, 1);
    applyStimulus(0, 0, 2'b00, 0, 0, 1);
    applyStimulus(0, 0, 2'b11, 32'h9, 32'h5, 1);
    applyStimulus(0, 1, 2'b11, 32'h9, 32'h6, 1);
    checkOutput("clr_valid", o_valid, 0);
    applyStimulus(0, 0, 2'b11, 32'h9, 32'h31, 1);
    checkOutput("clr_grant_hi_wait", o_valid, 0);
    applyStimulus(0, 0, 2'b10, 32'h9, 32'h32, 1);
    checkOutput("clr_data", o_data, {32'h32, 32'h31});
    checkOutput("clr_id", o_id, 1);
    applyStimulus(0, 0, 2'b00, 0, 0, 1);

    // Second word never arrives
    applyStimulus(1, 0, 2'b00, 0, 0, 1);
    applyStimulus(0, 0, 2'b01, 32'h7, 0, 1);
`ifdef PAIR_PACK_TIMEOUT_EN
    for (int c = 0; c < 3; c++) begin
      applyStimulus(0, 0, 2'b00, 0, 0, 1);
      checkOutput("to_wait", o_valid, 0);
    end
    applyStimulus(0, 0, 2'b00, 0, 0, 1);
    checkOutput("to_valid", o_valid, 1);
    checkOutput("to_data", o_data, {32'h0, 32'h7});
    checkOutput("to_partial", o_partial, 1);
    applyStimulus(0, 0, 2'b00, 0, 0, 1);
`else
    for (int c = 0; c < 10; c++) begin
      applyStimulus(0, 0, 2'b00, 0, 0, 1);
      checkOutput("hold_wait", o_valid, 0);
    end
    applyStimulus(0, 0, 2'b01, 32'h8, 0, 1);
    checkOutput("hold_data", o_data, {32'h8, 32'h7});
    checkOutput("hold_partial", o_partial, 0);
    applyStimulus(0, 0, 2'b00, 0, 0, 1);
`endif

    // Reset while a pair is stalled in OUT
    applyStimulus(1, 0, 2'b00, 0, 0, 1);
    applyStimulus(0, 0, 2'b01, 32'h1, 0, 1);
    applyStimulus(0, 0, 2'b01, 32'h2, 0, 1);
    applyStimulus(0, 0, 2'b00, 0, 0, 1);
    applyStimulus(0, 0, 2'b10, 0, 32'h3, 0);
    applyStimulus(0, 0, 2'b10, 0, 32'h4, 0);
    checkOutput("rst_out_pre", o_valid, 1);
    applyStimulus(1, 0, 2'b11, 32'h5, 32'h6, 0);
    checkOutput("rst_out_valid", o_valid, 0);
    checkOutput("rst_out_ready", o_ready, 0);
    applyStimulus(0, 0, 2'b11, 32'h50, 32'h60, 1);
    applyStimulus(0, 0, 2'b11, 32'h51, 32'h61, 1);
    checkOutput("rst_first_id", o_id, 0);
    checkOutput("rst_first_data", o_data, {32'h51, 32'h50});

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      applyStimulus($urandom_range(0, 79) == 0, $urandom_range(0, 29) == 0,
                    NR'($urandom_range(0, 3)), $urandom, $urandom,
                    $urandom_range(0, 9) < 7);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
